aes_pktbuf: RTL and testbench
=============================

# aes_pktbuf

Packet holding buffer and batch controller that sits on the far side of the AES manager's buffer port. It accepts up to NOPKT 128-bit packets from the host as 32-bit words and zero-pads a trailing partial packet. It then hands the batch to the AES manager with a one-cycle AesIrdy/AesSize start and services that manager's word reads and writes. On AesTrdy it drains the transformed words back to the host in order.

## Interface
Parameters:
- SBASE, 1: MSB of AesSize (64B buffer = 1, 128B = 2)
- ADDW, 3: MSB of word address (64B = 3, 128B = 4)
- NOPKT, 4: packet capacity (64B = 4, 128B = 8); capacity in words is NOPKT*4 = 2^(ADDW+1)

Ports:
- clk  in  1  single clock; all state on posedge
- rst  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- HostWr  in  1  write HostWrData at the fill pointer; honoured only when HostRdy=1
- HostWrData  in  32  fill word; word 0 is the packet MSW (bits 127:96)
- HostLast  in  1  qualifies HostWr; marks the final word of the batch
- HostRdy  out  1  buffer accepting fill words
- HostRd  in  1  pop one drain word; honoured only when HostRdVld=1
- HostRdData  out  32  mem[drain pointer], combinational
- HostRdVld  out  1  drain word available
- BatchDone  out  1  one-cycle pulse after the last drain pop
- AesIrdy  out  1  one-cycle batch start pulse to the AES manager
- AesSize  out  SBASE+1  packets in batch minus 1
- AesTrdy  in  1  AES manager finished the batch
- AesRd  in  1  AES manager read strobe; informational only, reads are asynchronous
- AesRdAdd  in  ADDW+1  AES manager read word address
- AesRdData  out  32  mem[AesRdAdd], combinational, in every state
- AesWr  in  1  AES manager write strobe
- AesWrAdd  in  ADDW+1  AES manager write word address
- AesWrData  in  32  AES manager write data

## Operation
- States: EMPTY=0, FILL=1, PAD=2, XFORM=3, DRAIN=4. The 3-bit state register resets to EMPTY.
- Word count WCnt is ADDW+2 bits wide, so it can hold the full count NOPKT*4. FPtr and DPtr are ADDW+1 bits.
- EMPTY/FILL:
  - HostRdy=1.
  - An accepted HostWr writes mem[FPtr], then increments FPtr and WCnt. The first write moves EMPTY to FILL.
  - The batch closes on the accepted write that has HostLast=1, or that makes WCnt reach NOPKT*4 (implied last).
  - On close: if the new FPtr[1:0]==0, go to XFORM; otherwise go to PAD.
  - HostLast without HostWr is ignored.
- PAD:
  - HostRdy=0.
  - Writes 32'h0 to mem[FPtr] once per cycle and increments FPtr/WCnt until FPtr[1:0]==0, then goes to XFORM.
- XFORM:
  - On entry, AesSize is registered as (WCnt-1)>>2, truncated to SBASE+1 bits.
  - AesIrdy is high only in the first XFORM cycle, because the manager re-samples AesIrdy in idle.
  - AesWr writes mem[AesWrAdd]<=AesWrData. AesWr outside XFORM is ignored.
  - AesTrdy moves to DRAIN with DPtr=0. AesTrdy outside XFORM is ignored.
- DRAIN:
  - HostRdVld = (DPtr != WCnt). An accepted HostRd increments DPtr.
  - Drained words include the zero-padded words.
  - The pop that makes DPtr == WCnt pulses BatchDone (registered, next cycle) and returns to EMPTY with WCnt, FPtr and DPtr cleared.
- A single memory write port is muxed by state: host or pad in FILL/PAD, AES in XFORM. There are never simultaneous writers.

## Timing
- Reset values: state=EMPTY, HostRdy=1, HostRdVld=0, BatchDone=0, AesIrdy=0, AesSize=0, pointers 0. Memory is not cleared.
- An async reset mid-batch aborts immediately. A pending drain is lost and no BatchDone is generated.
- Read data is zero-latency: AesRdData and HostRdData are combinational from their address or pointer.
- Closing write at edge n gives state XFORM (or PAD) at n+1. AesIrdy is high in cycle n+1 for a batch with no padding.
- PAD adds 4-FPtr[1:0] cycles before XFORM.
- An AesWr in the same cycle as AesTrdy still commits. DRAIN starts the next cycle, with HostRdVld=1 if WCnt>0.
- A full buffer (WCnt=NOPKT*4) gives AesSize=NOPKT-1, and FPtr wraps to 0.

## Structure
- Package aes_pktbuf_pkg holds:
  - state encodings
  - default SBASE/ADDW/NOPKT for the 64B and 128B variants
  - the words-per-packet constant 4
- Sub-module aes_pktbuf_ram: 2^(ADDW+1) x 32 memory with one synchronous write port and two asynchronous read ports (AES, drain).

## Test plan
- Fill 16 words 0x00..0x0F (ADDW=3) without HostLast:
  - implied close; AesIrdy is a single pulse with AesSize=3;
  - AES writes ~data to all 16 addresses; AesTrdy drains 0xFFFFFFFF..0xFFFFFFF0 in order;
  - BatchDone pulses once.
- Fill 5 words with HostLast on word 4:
  - PAD runs 3 cycles; AesSize=1; drain returns 8 words, the last 3 equal 0.
- HostWr during XFORM, and AesWr during FILL:
  - no memory change; AesRdData tracks AesRdAdd throughout.
- AesWr to address 7 and AesTrdy in the same cycle:
  - word 7 drains as the written value.
- Assert rst low mid-DRAIN after 3 pops:
  - all outputs return to reset values asynchronously; the next batch of 4 words drains from DPtr 0.
- Hold HostRd low in DRAIN:
  - HostRdVld and HostRdData remain stable; no BatchDone pulse.

Source files
------------

// File: rtl/aes_pktbuf_pkg.sv
// Shared types and constants for the AES packet buffer.
// Covers the 64B and 128B buffer variants.
package aes_pktbuf_pkg;

   typedef enum logic [2:0] {
      EMPTY = 3'd0,
      FILL  = 3'd1,
      PAD   = 3'd2,
      XFORM = 3'd3,
      DRAIN = 3'd4
   } state_t;

   localparam int SBASE_64  = 1;
   localparam int ADDW_64   = 3;
   localparam int NOPKT_64  = 4;
   localparam int SBASE_128 = 2;
   localparam int ADDW_128  = 4;
   localparam int NOPKT_128 = 8;

   localparam int WPP = 4;

endpackage

// File: rtl/aes_pktbuf_ram.sv
// Word store for the packet buffer: one sync write port,
// two async read ports (AES side and host drain side).
module aes_pktbuf_ram #(
   parameter int ADDW = 3
) (
   input  logic          clk,
   input  logic          we,
   input  logic [ADDW:0] wAdd,
   input  logic [31:0]   wData,
   input  logic [ADDW:0] aAdd,
   output logic [31:0]   aData,
   input  logic [ADDW:0] dAdd,
   output logic [31:0]   dData
);

   logic [31:0] mem [2**(ADDW+1)];

   always_ff @(posedge clk) begin
      if (we) mem[wAdd] <= wData;
   end

   assign aData = mem[aAdd];
   assign dData = mem[dAdd];

endmodule

// File: rtl/aes_pktbuf.sv
// Packet holding buffer and batch controller facing the
// AES manager buffer port: fill, pad, transform, drain.
module aes_pktbuf
   import aes_pktbuf_pkg::*;
#(
   parameter int SBASE = SBASE_64,
   parameter int ADDW  = ADDW_64,
   parameter int NOPKT = NOPKT_64
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           HostWr,
   input  logic [31:0]    HostWrData,
   input  logic           HostLast,
   output logic           HostRdy,
   input  logic           HostRd,
   output logic [31:0]    HostRdData,
   output logic           HostRdVld,
   output logic           BatchDone,
   output logic           AesIrdy,
   output logic [SBASE:0] AesSize,
   input  logic           AesTrdy,
   input  logic           AesRd,
   input  logic [ADDW:0]  AesRdAdd,
   output logic [31:0]    AesRdData,
   input  logic           AesWr,
   input  logic [ADDW:0]  AesWrAdd,
   input  logic [31:0]    AesWrData
);

   localparam logic [ADDW+1:0] FULLCNT = (ADDW+2)'(NOPKT*WPP);

   state_t          state;
   logic [ADDW:0]   fPtr;
   logic [ADDW:0]   dPtr;
   logic [ADDW+1:0] wCnt;

   logic [ADDW:0]   fPtrNx;
   logic [ADDW+1:0] wCntNx;
   logic [ADDW+1:0] dPtrNx;
   logic            hostAcc;
   logic            padWr;
   logic            aesAcc;
   logic            popAcc;
   logic            closeFill;
   logic            memWe;
   logic [ADDW:0]   memWa;
   logic [31:0]     memWd;
   logic            unusedAesRd;

   // Reads are asynchronous, so the read strobe carries no information.
   assign unusedAesRd = AesRd;

   function automatic logic [SBASE:0] sizeOf(input logic [ADDW+1:0] n);
      return (SBASE+1)'((n - (ADDW+2)'(1)) >> 2);
   endfunction

   assign fPtrNx    = fPtr + 1'b1;
   assign wCntNx    = wCnt + 1'b1;
   assign dPtrNx    = {1'b0, dPtr} + 1'b1;
   assign HostRdy   = (state == EMPTY) || (state == FILL);
   assign HostRdVld = (state == DRAIN) && ({1'b0, dPtr} != wCnt);
   assign hostAcc   = HostRdy && HostWr;
   assign padWr     = (state == PAD);
   assign aesAcc    = (state == XFORM) && AesWr;
   assign popAcc    = HostRdVld && HostRd;
   assign closeFill = hostAcc && (HostLast || (wCntNx == FULLCNT));
   assign memWe     = hostAcc || padWr || aesAcc;

   always_comb begin
      memWa = fPtr;
      memWd = HostWrData;
      unique case (1'b1)
         aesAcc: begin
            memWa = AesWrAdd;
            memWd = AesWrData;
         end
         padWr:   memWd = '0;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= EMPTY;
         fPtr      <= '0;
         dPtr      <= '0;
         wCnt      <= '0;
         AesIrdy   <= 1'b0;
         AesSize   <= '0;
         BatchDone <= 1'b0;
      end else begin
         AesIrdy   <= 1'b0;
         BatchDone <= 1'b0;
         unique case (state)
            EMPTY, FILL: begin
               if (hostAcc) begin
                  fPtr  <= fPtrNx;
                  wCnt  <= wCntNx;
                  state <= FILL;
                  if (closeFill) begin
                     if (fPtrNx[1:0] == 2'd0) begin
                        state   <= XFORM;
                        AesIrdy <= 1'b1;
                        AesSize <= sizeOf(wCntNx);
                     end else begin
                        state <= PAD;
                     end
                  end
               end
            end
            PAD: begin
               fPtr <= fPtrNx;
               wCnt <= wCntNx;
               if (fPtrNx[1:0] == 2'd0) begin
                  state   <= XFORM;
                  AesIrdy <= 1'b1;
                  AesSize <= sizeOf(wCntNx);
               end
            end
            XFORM: begin
               if (AesTrdy) begin
                  state <= DRAIN;
                  dPtr  <= '0;
               end
            end
            DRAIN: begin
               if (popAcc) begin
                  if (dPtrNx == wCnt) begin
                     state     <= EMPTY;
                     wCnt      <= '0;
                     fPtr      <= '0;
                     dPtr      <= '0;
                     BatchDone <= 1'b1;
                  end else begin
                     dPtr <= dPtrNx[ADDW:0];
                  end
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   aes_pktbuf_ram #(.ADDW(ADDW)) uRam (
      .clk   (clk),
      .we    (memWe),
      .wAdd  (memWa),
      .wData (memWd),
      .aAdd  (AesRdAdd),
      .aData (AesRdData),
      .dAdd  (dPtr),
      .dData (HostRdData)
   );

endmodule

// File: tb/tb_aes_pktbuf.sv
// Directed bench for aes_pktbuf (64B variant): a vector table
// for a padded batch plus hand-written multi-cycle sequences.
module tb_aes_pktbuf;

   logic        clk;
   logic        rst;
   logic        HostWr;
   logic [31:0] HostWrData;
   logic        HostLast;
   logic        HostRdy;
   logic        HostRd;
   logic [31:0] HostRdData;
   logic        HostRdVld;
   logic        BatchDone;
   logic        AesIrdy;
   logic [1:0]  AesSize;
   logic        AesTrdy;
   logic        AesRd;
   logic [3:0]  AesRdAdd;
   logic [31:0] AesRdData;
   logic        AesWr;
   logic [3:0]  AesWrAdd;
   logic [31:0] AesWrData;

   int nVec = 0;
   int nBad = 0;
   int irdyCnt = 0;
   int doneCnt = 0;

   aes_pktbuf #(.SBASE(1), .ADDW(3), .NOPKT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .HostWr     (HostWr),
      .HostWrData (HostWrData),
      .HostLast   (HostLast),
      .HostRdy    (HostRdy),
      .HostRd     (HostRd),
      .HostRdData (HostRdData),
      .HostRdVld  (HostRdVld),
      .BatchDone  (BatchDone),
      .AesIrdy    (AesIrdy),
      .AesSize    (AesSize),
      .AesTrdy    (AesTrdy),
      .AesRd      (AesRd),
      .AesRdAdd   (AesRdAdd),
      .AesRdData  (AesRdData),
      .AesWr      (AesWr),
      .AesWrAdd   (AesWrAdd),
      .AesWrData  (AesWrData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (AesIrdy) irdyCnt++;
      if (BatchDone) doneCnt++;
   end

   typedef struct {
      logic        wr;
      logic [31:0] wd;
      logic        last;
      logic        rd;
      logic        aWr;
      logic [3:0]  aWa;
      logic [31:0] aWd;
      logic        trdy;
      logic [3:0]  aRa;
      logic        eRdy;
      logic        eVld;
      logic        eDone;
      logic        eIrdy;
      logic [1:0]  eSize;
      logic        chkRd;
      logic [31:0] eRd;
      logic        chkA;
      logic [31:0] eA;
   } vec_t;

   vec_t tv [21];

   function automatic vec_t mk(
      input logic wr, input logic [31:0] wd, input logic last,
      input logic rd, input logic aWr, input logic [3:0] aWa,
      input logic [31:0] aWd, input logic trdy, input logic [3:0] aRa,
      input logic eRdy, input logic eVld, input logic eDone,
      input logic eIrdy, input logic [1:0] eSize,
      input logic chkRd, input logic [31:0] eRd,
      input logic chkA, input logic [31:0] eA);
      vec_t v;
      v.wr = wr;     v.wd = wd;       v.last = last;
      v.rd = rd;     v.aWr = aWr;     v.aWa = aWa;
      v.aWd = aWd;   v.trdy = trdy;   v.aRa = aRa;
      v.eRdy = eRdy; v.eVld = eVld;   v.eDone = eDone;
      v.eIrdy = eIrdy; v.eSize = eSize;
      v.chkRd = chkRd; v.eRd = eRd;
      v.chkA = chkA;   v.eA = eA;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      HostWr = 0; HostWrData = 0; HostLast = 0; HostRd = 0;
      AesTrdy = 0; AesRd = 0; AesRdAdd = 0;
      AesWr = 0; AesWrAdd = 0; AesWrData = 0;
   endtask

   task automatic nx();
      @(negedge clk);
      idle();
   endtask

   initial begin
      logic [31:0] w;
      idle();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst.rdy", HostRdy, 1);
      chk("rst.vld", HostRdVld, 0);
      chk("rst.done", BatchDone, 0);
      chk("rst.irdy", AesIrdy, 0);
      chk("rst.size", AesSize, 0);
      @(negedge clk);
      rst = 1'b1;

      // 5-word batch: pad 3, HostWr in XFORM, AesWr in FILL,
      // AesWr to word 7 together with AesTrdy.
      tv[0]  = mk(1,32'h10,0,0, 0,0,0,0,0,  1,0,0,0,0, 0,0, 0,0);
      tv[1]  = mk(1,32'h11,0,0, 0,0,0,0,0,  1,0,0,0,0, 0,0, 1,32'h10);
      tv[2]  = mk(1,32'h12,0,0, 1,0,32'hBADBAD01,0,1,
                  1,0,0,0,0, 0,0, 1,32'h11);
      tv[3]  = mk(1,32'h13,0,0, 0,0,0,0,0,  1,0,0,0,0, 0,0, 1,32'h10);
      tv[4]  = mk(1,32'h14,1,0, 0,0,0,0,2,  1,0,0,0,0, 0,0, 1,32'h12);
      tv[5]  = mk(0,0,0,0, 0,0,0,0,0,       0,0,0,0,0, 0,0, 1,32'h10);
      tv[6]  = mk(0,0,0,0, 0,0,0,0,5,       0,0,0,0,0, 0,0, 1,32'h0);
      tv[7]  = mk(0,0,0,0, 0,0,0,0,6,       0,0,0,0,0, 0,0, 1,32'h0);
      tv[8]  = mk(1,32'hDEADBEEF,0,0, 0,0,0,0,7,
                  0,0,0,1,1, 0,0, 1,32'h0);
      tv[9]  = mk(0,0,0,0, 1,4,32'h44444444,0,4,
                  0,0,0,0,1, 0,0, 1,32'h14);
      tv[10] = mk(0,0,0,0, 1,7,32'h77777777,1,4,
                  0,0,0,0,1, 0,0, 1,32'h44444444);
      tv[11] = mk(0,0,0,1, 0,0,0,0,7, 0,1,0,0,1, 1,32'h10, 1,32'h77777777);
      tv[12] = mk(0,0,0,1, 0,0,0,0,0, 0,1,0,0,1, 1,32'h11, 0,0);
      tv[13] = mk(0,0,0,1, 0,0,0,0,0, 0,1,0,0,1, 1,32'h12, 0,0);
      tv[14] = mk(0,0,0,1, 0,0,0,0,0, 0,1,0,0,1, 1,32'h13, 0,0);
      tv[15] = mk(0,0,0,1, 0,0,0,0,0, 0,1,0,0,1, 1,32'h44444444, 0,0);
      tv[16] = mk(0,0,0,1, 0,0,0,0,0, 0,1,0,0,1, 1,32'h0, 0,0);
      tv[17] = mk(0,0,0,1, 0,0,0,0,0, 0,1,0,0,1, 1,32'h0, 0,0);
      tv[18] = mk(0,0,0,1, 0,0,0,0,0, 0,1,0,0,1, 1,32'h77777777, 0,0);
      tv[19] = mk(0,0,0,0, 0,0,0,0,0, 1,0,1,0,1, 0,0, 1,32'h10);
      tv[20] = mk(0,0,1,0, 0,0,0,0,3, 1,0,0,0,1, 0,0, 1,32'h13);

      for (int i = 0; i < 21; i++) begin
         nx();
         HostWr = tv[i].wr;     HostWrData = tv[i].wd;
         HostLast = tv[i].last; HostRd = tv[i].rd;
         AesWr = tv[i].aWr;     AesWrAdd = tv[i].aWa;
         AesWrData = tv[i].aWd; AesTrdy = tv[i].trdy;
         AesRdAdd = tv[i].aRa;
         #1;
         chk($sformatf("t%0d.rdy", i), HostRdy, tv[i].eRdy);
         chk($sformatf("t%0d.vld", i), HostRdVld, tv[i].eVld);
         chk($sformatf("t%0d.done", i), BatchDone, tv[i].eDone);
         chk($sformatf("t%0d.irdy", i), AesIrdy, tv[i].eIrdy);
         chk($sformatf("t%0d.size", i), AesSize, tv[i].eSize);
         if (tv[i].chkRd)
            chk($sformatf("t%0d.rdat", i), HostRdData, tv[i].eRd);
         if (tv[i].chkA)
            chk($sformatf("t%0d.adat", i), AesRdData, tv[i].eA);
      end

      // Full 16-word batch with implied close.
      irdyCnt = 0;
      doneCnt = 0;
      for (int i = 0; i < 16; i++) begin
         nx();
         HostWr = 1; HostWrData = 32'(i);
         #1;
         chk($sformatf("f%0d.rdy", i), HostRdy, 1);
         chk($sformatf("f%0d.irdy", i), AesIrdy, 0);
      end
      nx(); #1;
      chk("full.irdy", AesIrdy, 1);
      chk("full.size", AesSize, 3);
      chk("full.rdy", HostRdy, 0);
      for (int i = 0; i < 16; i++) begin
         nx();
         w = 32'(i);
         AesWr = 1; AesWrAdd = 4'(i); AesWrData = ~w; AesRdAdd = 4'(i);
         #1;
         chk($sformatf("x%0d.adat", i), AesRdData, w);
         chk($sformatf("x%0d.irdy", i), AesIrdy, 0);
      end
      nx();
      AesTrdy = 1; AesRdAdd = 4'd15;
      #1;
      chk("full.adat15", AesRdData, 32'hFFFFFFF0);
      for (int i = 0; i < 16; i++) begin
         nx();
         w = 32'(i);
         HostRd = 1;
         #1;
         chk($sformatf("d%0d.vld", i), HostRdVld, 1);
         chk($sformatf("d%0d.rdat", i), HostRdData, ~w);
         chk($sformatf("d%0d.done", i), BatchDone, 0);
      end
      nx(); #1;
      chk("full.done", BatchDone, 1);
      chk("full.vld", HostRdVld, 0);
      chk("full.rdyback", HostRdy, 1);
      nx(); #1;
      chk("full.done0", BatchDone, 0);
      chk("full.irdycnt", irdyCnt, 1);
      chk("full.donecnt", doneCnt, 1);

      // 8-word batch, stall, then async reset after 3 pops.
      doneCnt = 0;
      for (int i = 0; i < 8; i++) begin
         nx();
         HostWr = 1; HostWrData = 32'h30 + 32'(i); HostLast = (i == 7);
      end
      nx(); #1;
      chk("b8.irdy", AesIrdy, 1);
      chk("b8.size", AesSize, 1);
      nx(); AesTrdy = 1;
      for (int i = 0; i < 3; i++) begin
         nx(); HostRd = 1; #1;
         chk($sformatf("b8.d%0d", i), HostRdData, 32'h30 + 32'(i));
      end
      for (int k = 0; k < 3; k++) begin
         nx(); #1;
         chk($sformatf("hold%0d.vld", k), HostRdVld, 1);
         chk($sformatf("hold%0d.rdat", k), HostRdData, 32'h33);
         chk($sformatf("hold%0d.done", k), BatchDone, 0);
      end
      nx();
      #2 rst = 1'b0;
      #1;
      chk("arst.rdy", HostRdy, 1);
      chk("arst.vld", HostRdVld, 0);
      chk("arst.done", BatchDone, 0);
      chk("arst.irdy", AesIrdy, 0);
      chk("arst.size", AesSize, 0);
      nx();
      rst = 1'b1;
      nx(); #1;
      chk("post.done", BatchDone, 0);
      chk("post.rdy", HostRdy, 1);

      for (int i = 0; i < 4; i++) begin
         nx();
         HostWr = 1; HostWrData = 32'h50 + 32'(i); HostLast = (i == 3);
      end
      nx(); #1;
      chk("b4.irdy", AesIrdy, 1);
      chk("b4.size", AesSize, 0);
      nx(); AesTrdy = 1;
      for (int i = 0; i < 4; i++) begin
         nx(); HostRd = 1; #1;
         chk($sformatf("b4.v%0d", i), HostRdVld, 1);
         chk($sformatf("b4.d%0d", i), HostRdData, 32'h50 + 32'(i));
      end
      nx(); #1;
      chk("b4.done", BatchDone, 1);
      nx(); #1;
      chk("b4.donecnt", doneCnt, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
      $finish;
   end

endmodule
